// File: rtl/arp_server_hls_dl_pkg.sv
// Shared types for the ARP-server deadlock report unit: FSM state encoding and
// the origin-index width helper.
package arp_server_hls_dl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ORIGIN = 3'd1,
    ST_TRACE  = 3'd2,
    ST_REPORT = 3'd3,
    ST_HOLD   = 3'd4
  } dl_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int dl_id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arp_server_hls_dl_prio_enc.sv
// Lowest-index-wins priority encoder used to choose the deadlock origin when
// several detect units fire in the same cycle.
module arp_server_hls_dl_prio_enc
  import arp_server_hls_dl_pkg::*;
#(
  parameter int PROC_NUM = 4,
  parameter int IW       = dl_id_width(PROC_NUM)
) (
  input  logic [PROC_NUM-1:0] i_vec,
  output logic [IW-1:0]       o_idx,
  output logic                o_valid
);

  always_comb begin
    o_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IW'(i);
    end
  end

  assign o_valid = |i_vec;

endmodule

// File: rtl/arp_server_hls_deadlock_report_unit.sv
// Deadlock report unit: picks an origin, traces the token ring, and holds a
// sticky report. Build macro ARP_DL_REPORT_TIMEOUT_EN enables the trace timeout.
//
// state  | meaning
// IDLE   | waiting for any dl_detect_vec bit
// ORIGIN | one-cycle origin strobe, mask seeded with origin
// TRACE  | collecting token_vec until origin token returns (or timeout)
// REPORT | report_valid held until report_ready
// HOLD   | report consumed, flag sticky until clear
module arp_server_hls_deadlock_report_unit
  import arp_server_hls_dl_pkg::*;
#(
  parameter int PROC_NUM      = 4,
  parameter int TRACE_TIMEOUT = 64
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [PROC_NUM-1:0]                 dl_detect_vec,
  input  logic [PROC_NUM-1:0]                 token_vec,
  input  logic                                clear,
  input  logic                                report_ready,
  output logic [PROC_NUM-1:0]                 origin,
  output logic                                token_clear,
  output logic                                dl_detect_out,
  output logic                                report_valid,
  output logic [dl_id_width(PROC_NUM)-1:0]    dl_origin_id,
  output logic [PROC_NUM-1:0]                 dl_proc_mask,
  output logic                                dl_timeout
);

  localparam int IW = dl_id_width(PROC_NUM);

  dl_state_t           r_state, w_state_nxt;
  logic [PROC_NUM-1:0] r_origin, w_origin_nxt;
  logic                r_token_clear, w_token_clear_nxt;
  logic                r_detect, w_detect_nxt;
  logic                r_valid, w_valid_nxt;
  logic [IW-1:0]       r_origin_id, w_origin_id_nxt;
  logic [PROC_NUM-1:0] r_mask, w_mask_nxt;
  logic [IW-1:0]       w_enc_idx;
  logic                w_enc_valid;

`ifdef ARP_DL_REPORT_TIMEOUT_EN
  localparam int TW = dl_id_width(TRACE_TIMEOUT);
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_timeout, w_timeout_nxt;
`endif

  arp_server_hls_dl_prio_enc #(
    .PROC_NUM (PROC_NUM),
    .IW       (IW)
  ) u_prio_enc (
    .i_vec   (dl_detect_vec),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_origin_nxt      = '0;
    w_token_clear_nxt = 1'b0;
    w_detect_nxt      = r_detect;
    w_valid_nxt       = r_valid;
    w_origin_id_nxt   = r_origin_id;
    w_mask_nxt        = r_mask;
`ifdef ARP_DL_REPORT_TIMEOUT_EN
    w_timer_nxt       = r_timer;
    w_timeout_nxt     = r_timeout;
`endif
    if (clear) begin
      // Tokens may still be circulating when a trace is aborted, so flush them.
      w_state_nxt       = ST_IDLE;
      w_token_clear_nxt = (r_state == ST_TRACE);
      w_detect_nxt      = 1'b0;
      w_valid_nxt       = 1'b0;
      w_origin_id_nxt   = '0;
      w_mask_nxt        = '0;
`ifdef ARP_DL_REPORT_TIMEOUT_EN
      w_timer_nxt       = '0;
      w_timeout_nxt     = 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_enc_valid) begin
            w_origin_id_nxt         = w_enc_idx;
            w_detect_nxt            = 1'b1;
            w_origin_nxt[w_enc_idx] = 1'b1;
            w_state_nxt             = ST_ORIGIN;
          end
        end
        ST_ORIGIN: begin
          w_mask_nxt              = '0;
          w_mask_nxt[r_origin_id] = 1'b1;
`ifdef ARP_DL_REPORT_TIMEOUT_EN
          w_timer_nxt             = '0;
`endif
          w_state_nxt             = ST_TRACE;
        end
        ST_TRACE: begin
          w_mask_nxt = r_mask | token_vec;
`ifdef ARP_DL_REPORT_TIMEOUT_EN
          if (r_timer != '1) w_timer_nxt = r_timer + TW'(1);
`endif
          if (token_vec[r_origin_id]) begin
            w_token_clear_nxt = 1'b1;
            w_valid_nxt       = 1'b1;
            w_state_nxt       = ST_REPORT;
`ifdef ARP_DL_REPORT_TIMEOUT_EN
            w_timeout_nxt     = 1'b0;
          end else if (r_timer == TW'(TRACE_TIMEOUT - 1)) begin
            w_token_clear_nxt = 1'b1;
            w_valid_nxt       = 1'b1;
            w_timeout_nxt     = 1'b1;
            w_state_nxt       = ST_REPORT;
`endif
          end
        end
        ST_REPORT: begin
          if (r_valid && report_ready) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          w_state_nxt = ST_HOLD;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_origin      <= '0;
      r_token_clear <= 1'b0;
      r_detect      <= 1'b0;
      r_valid       <= 1'b0;
      r_origin_id   <= '0;
      r_mask        <= '0;
`ifdef ARP_DL_REPORT_TIMEOUT_EN
      r_timer       <= '0;
      r_timeout     <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_origin      <= w_origin_nxt;
      r_token_clear <= w_token_clear_nxt;
      r_detect      <= w_detect_nxt;
      r_valid       <= w_valid_nxt;
      r_origin_id   <= w_origin_id_nxt;
      r_mask        <= w_mask_nxt;
`ifdef ARP_DL_REPORT_TIMEOUT_EN
      r_timer       <= w_timer_nxt;
      r_timeout     <= w_timeout_nxt;
`endif
    end
  end

  assign origin        = r_origin;
  assign token_clear   = r_token_clear;
  assign dl_detect_out = r_detect;
  assign report_valid  = r_valid;
  assign dl_origin_id  = r_origin_id;
  assign dl_proc_mask  = r_mask;
`ifdef ARP_DL_REPORT_TIMEOUT_EN
  assign dl_timeout    = r_timeout;
`else
  assign dl_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_arp_server_hls_deadlock_report_unit.sv
// Scoreboard bench for the deadlock report unit (PROC_NUM=4, TRACE_TIMEOUT=8);
// follows ARP_DL_REPORT_TIMEOUT_EN for the timeout scenarios.
module tb_arp_server_hls_deadlock_report_unit;

  localparam int PN = 4;
  localparam int TT = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] mask;
    logic       to;
  } rep_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [PN-1:0] dl_detect_vec = '0;
  logic [PN-1:0] token_vec = '0;
  logic          clear = 1'b0;
  logic          report_ready = 1'b0;
  logic [PN-1:0] origin;
  logic          token_clear;
  logic          dl_detect_out;
  logic          report_valid;
  logic [1:0]    dl_origin_id;
  logic [PN-1:0] dl_proc_mask;
  logic          dl_timeout;

  logic [3:0] q_origin[$];
  bit         q_tclr[$];
  rep_t       q_rep[$];
  rep_t       mon_rep;
  int         checks = 0;
  int         errors = 0;

  always #5 clock = ~clock;

  arp_server_hls_deadlock_report_unit #(
    .PROC_NUM      (PN),
    .TRACE_TIMEOUT (TT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .dl_detect_vec (dl_detect_vec),
    .token_vec     (token_vec),
    .clear         (clear),
    .report_ready  (report_ready),
    .origin        (origin),
    .token_clear   (token_clear),
    .dl_detect_out (dl_detect_out),
    .report_valid  (report_valid),
    .dl_origin_id  (dl_origin_id),
    .dl_proc_mask  (dl_proc_mask),
    .dl_timeout    (dl_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected no event", name, act);
  endtask

  task automatic push_rep(input logic [1:0] id, input logic [3:0] mask, input logic to);
    rep_t r;
    r.id = id;
    r.mask = mask;
    r.to = to;
    q_rep.push_back(r);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_origin"}, origin, 0);
    chk({tag, "_tclr"}, token_clear, 0);
    chk({tag, "_detect"}, dl_detect_out, 0);
    chk({tag, "_valid"}, report_valid, 0);
    chk({tag, "_id"}, dl_origin_id, 0);
    chk({tag, "_mask"}, dl_proc_mask, 0);
    chk({tag, "_timeout"}, dl_timeout, 0);
  endtask

  // Monitor: every DUT event must match the next expected entry.
  always @(negedge clock) begin
    if (reset) begin
      if (origin != '0) begin
        chk("origin_tclr_exclusive", token_clear, 0);
        if (q_origin.size() == 0) unexpected("unexpected_origin", origin);
        else chk("origin", origin, q_origin.pop_front());
      end
      if (token_clear) begin
        if (q_tclr.size() == 0) unexpected("unexpected_token_clear", token_clear);
        else chk("token_clear", token_clear, q_tclr.pop_front());
      end
      if (report_valid && report_ready) begin
        if (q_rep.size() == 0) unexpected("unexpected_report", {dl_origin_id, dl_proc_mask, dl_timeout});
        else begin
          mon_rep = q_rep.pop_front();
          chk("report_id", dl_origin_id, mon_rep.id);
          chk("report_mask", dl_proc_mask, mon_rep.mask);
          chk("report_timeout", dl_timeout, mon_rep.to);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    step();

    // Single detect, origin 2, immediate token return; HOLD ignores detects.
    dl_detect_vec = 4'b0100;
    q_origin.push_back(4'b0100);
    step();
    dl_detect_vec = '0;
    chk("t1_id", dl_origin_id, 2);
    chk("t1_detect", dl_detect_out, 1);
    step();
    chk("t1_origin_off", origin, 0);
    token_vec = 4'b0100;
    q_tclr.push_back(1'b1);
    push_rep(2'd2, 4'b0100, 1'b0);
    report_ready = 1'b1;
    step();
    token_vec = '0;
    chk("t1_valid", report_valid, 1);
    step();
    report_ready = 1'b0;
    chk("t1_valid_drop", report_valid, 0);
    chk("t1_detect_sticky", dl_detect_out, 1);
    dl_detect_vec = 4'b0001;
    step();
    dl_detect_vec = '0;
    step();
    chk("t1_hold_detect", dl_detect_out, 1);
    chk("t1_hold_id", dl_origin_id, 2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t1_clear_detect", dl_detect_out, 0);
    chk("t1_clear_id", dl_origin_id, 0);
    chk("t1_clear_mask", dl_proc_mask, 0);

    // Two detects -> lowest index 1; tokens accumulate; report held while ready low.
    dl_detect_vec = 4'b1010;
    q_origin.push_back(4'b0010);
    step();
    dl_detect_vec = '0;
    chk("t2_id", dl_origin_id, 1);
    step();
    token_vec = 4'b0001;
    dl_detect_vec = 4'b0001;
    step();
    dl_detect_vec = '0;
    token_vec = 4'b1000;
    step();
    token_vec = 4'b0010;
    q_tclr.push_back(1'b1);
    push_rep(2'd1, 4'b1011, 1'b0);
    step();
    token_vec = '0;
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", report_valid, 1);
      chk("t2_hold_id", dl_origin_id, 1);
      chk("t2_hold_mask", dl_proc_mask, 4'b1011);
      chk("t2_hold_timeout", dl_timeout, 0);
      step();
    end
    report_ready = 1'b1;
    step();
    report_ready = 1'b0;
    chk("t2_valid_drop", report_valid, 0);
    chk("t2_detect_sticky", dl_detect_out, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;

`ifdef ARP_DL_REPORT_TIMEOUT_EN
    // Origin 0 with no token return: timeout after 8 TRACE cycles.
    dl_detect_vec = 4'b0001;
    q_origin.push_back(4'b0001);
    step();
    dl_detect_vec = '0;
    step();
    q_tclr.push_back(1'b1);
    push_rep(2'd0, 4'b0001, 1'b1);
    n = 0;
    while (!token_clear && n < 20) begin
      step();
      n++;
    end
    chk("t3_trace_len", n, 8);
    chk("t3_timeout", dl_timeout, 1);
    chk("t3_mask", dl_proc_mask, 4'b0001);
    report_ready = 1'b1;
    step();
    report_ready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;

    // Token return on the last TRACE cycle wins over the timeout.
    dl_detect_vec = 4'b0001;
    q_origin.push_back(4'b0001);
    step();
    dl_detect_vec = '0;
    step();
    repeat (7) step();
    chk("t3b_no_early_end", report_valid, 0);
    token_vec = 4'b0001;
    q_tclr.push_back(1'b1);
    push_rep(2'd0, 4'b0001, 1'b0);
    step();
    token_vec = '0;
    chk("t3b_timeout", dl_timeout, 0);
    report_ready = 1'b1;
    step();
    report_ready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
`else
    // Without the timer the trace waits indefinitely.
    dl_detect_vec = 4'b0001;
    q_origin.push_back(4'b0001);
    step();
    dl_detect_vec = '0;
    step();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (token_clear || report_valid) seen = 1;
      step();
    end
    chk("t3_no_end", seen, 0);
    chk("t3_detect", dl_detect_out, 1);
    chk("t3_mask", dl_proc_mask, 4'b0001);
    q_tclr.push_back(1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t3_clear_tclr", token_clear, 1);
    step();
`endif

    // Clear mid-TRACE flushes tokens, then a fresh trace from origin 0.
    dl_detect_vec = 4'b0100;
    q_origin.push_back(4'b0100);
    step();
    dl_detect_vec = '0;
    step();
    token_vec = 4'b0001;
    step();
    token_vec = '0;
    clear = 1'b1;
    q_tclr.push_back(1'b1);
    step();
    clear = 1'b0;
    chk("t4_clear_tclr", token_clear, 1);
    chk("t4_clear_valid", report_valid, 0);
    chk("t4_clear_detect", dl_detect_out, 0);
    chk("t4_clear_mask", dl_proc_mask, 0);
    chk("t4_clear_id", dl_origin_id, 0);
    step();
    chk("t4_tclr_single", token_clear, 0);
    dl_detect_vec = 4'b0001;
    q_origin.push_back(4'b0001);
    step();
    dl_detect_vec = '0;
    chk("t4_new_id", dl_origin_id, 0);
    chk("t4_new_detect", dl_detect_out, 1);
    step();
    token_vec = 4'b0001;
    q_tclr.push_back(1'b1);
    push_rep(2'd0, 4'b0001, 1'b0);
    report_ready = 1'b1;
    step();
    token_vec = '0;
    step();
    report_ready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;

    // Reset during TRACE: outputs drop at once, no token_clear afterwards.
    dl_detect_vec = 4'b1000;
    q_origin.push_back(4'b1000);
    step();
    dl_detect_vec = '0;
    step();
    token_vec = 4'b0001;
    step();
    token_vec = '0;
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("t5_reset");
    step();
    step();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (token_clear) seen = 1;
    end
    chk("t5_no_tclr", seen, 0);
    chk("t5_detect", dl_detect_out, 0);

    chk("q_origin_empty", q_origin.size(), 0);
    chk("q_tclr_empty", q_tclr.size(), 0);
    chk("q_rep_empty", q_rep.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
